// File: rtl/div_sched_pkg.sv
// Shared types and default sizing for the iterative divide scheduler.
// Latency: n/a. Backpressure: n/a.
// Holds the FSM state encoding, default operand widths and counter width.
package div_sched_pkg;

    localparam int DW_DEF = 4;
    localparam int BW_DEF = 2;
    localparam int CNT_W  = $clog2(DW_DEF + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ITER,
        ST_FIX,
        ST_DONE
    } state_t;

endpackage

// File: rtl/div_nr_step.sv
// One non-restoring division step on the shifted {P,Q} pair.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
module div_nr_step #(
    parameter int DW = 4,
    parameter int BW = 2
) (
    input  logic [BW+1:0] p_i,
    input  logic [DW-1:0] q_i,
    input  logic [BW-1:0] b_i,
    output logic [BW+1:0] p_o,
    output logic [DW-1:0] q_o
);

    logic [BW+2:0] p_ext;
    logic [BW+2:0] b_ext;
    logic [BW+2:0] sum;

    // A guard bit keeps the quotient bit correct when the shifted remainder
    // overflows P, which only happens for a zero divisor.
    always_comb begin
        p_ext = {p_i[BW+1], p_i, q_i[DW-1]};
        b_ext = {{3{1'b0}}, b_i};
        if (p_i[BW+1]) begin
            sum = p_ext + b_ext;
        end else begin
            sum = p_ext - b_ext;
        end
        p_o = sum[BW+1:0];
        q_o = {q_i[DW-2:0], ~sum[BW+2]};
    end

endmodule

// File: rtl/div_sched.sv
// Two-requester round-robin scheduler around a shared iterative non-restoring divider.
// Latency: response DW+1 cycles after accept (1 for zero divisor with DIV_SCHED_DZ_EN).
// Backpressure: one divide in flight; requests wait while busy, response holds until rsp_ready.
module div_sched
    import div_sched_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int BW = BW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [DW-1:0] req0_a,
    input  logic [BW-1:0] req0_b,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [DW-1:0] req1_a,
    input  logic [BW-1:0] req1_b,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [DW-1:0] rsp_quot,
    output logic [BW-1:0] rsp_rem,
    output logic          rsp_dz
);

    localparam int CW = $clog2(DW + 1);
    localparam int PW = BW + 2;

    state_t        state_q, state_d;
    logic [PW-1:0] p_q, p_d, step_p;
    logic [DW-1:0] q_q, q_d, step_q;
    logic [BW-1:0] b_q, b_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          id_q, id_d;
    logic          last_q, last_d;
    logic          gnt0, gnt1;
    logic [DW-1:0] a_sel;
    logic [BW-1:0] b_sel;
`ifdef DIV_SCHED_DZ_EN
    logic          dz_q, dz_d;
`endif

    // Tie goes to the requester that was not granted last.
    always_comb begin
        gnt0  = req0_valid && (!req1_valid || last_q);
        gnt1  = req1_valid && (!req0_valid || !last_q);
        a_sel = gnt1 ? req1_a : req0_a;
        b_sel = gnt1 ? req1_b : req0_b;
    end

    assign req0_ready = rst_n && (state_q == ST_IDLE) && gnt0;
    assign req1_ready = rst_n && (state_q == ST_IDLE) && gnt1;

    div_nr_step #(
        .DW (DW),
        .BW (BW)
    ) u_step (
        .p_i (p_q),
        .q_i (q_q),
        .b_i (b_q),
        .p_o (step_p),
        .q_o (step_q)
    );

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        q_d     = q_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        last_d  = last_q;
`ifdef DIV_SCHED_DZ_EN
        dz_d    = dz_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (gnt0 || gnt1) begin
                    id_d    = gnt1;
                    last_d  = gnt1;
                    q_d     = a_sel;
                    b_d     = b_sel;
                    p_d     = '0;
                    cnt_d   = '0;
                    state_d = ST_ITER;
`ifdef DIV_SCHED_DZ_EN
                    dz_d    = 1'b0;
                    if (b_sel == '0) begin
                        q_d     = '1;
                        p_d     = {{2{1'b0}}, a_sel[BW-1:0]};
                        dz_d    = 1'b1;
                        state_d = ST_DONE;
                    end
`endif
                end
            end
            ST_ITER: begin
                p_d   = step_p;
                q_d   = step_q;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(DW - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (p_q[PW-1]) begin
                    p_d = p_q + {{2{1'b0}}, b_q};
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            p_q     <= '0;
            q_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            q_q     <= q_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            last_q  <= last_d;
        end
    end

`ifdef DIV_SCHED_DZ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dz_q <= 1'b0;
        end else begin
            dz_q <= dz_d;
        end
    end
    assign rsp_dz = dz_q;
`else
    assign rsp_dz = 1'b0;
`endif

    assign rsp_valid = (state_q == ST_DONE);
    assign rsp_id    = id_q;
    assign rsp_quot  = q_q;
    assign rsp_rem   = p_q[BW-1:0];

endmodule

// File: tb/tb_div_sched.sv
// Self-checking bench for div_sched: vector table, multi-cycle corner sequences,
// exhaustive sweep and randomized requests against an arithmetic reference.
module tb_div_sched;

    localparam int DW = 4;
    localparam int BW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [DW-1:0] req0_a, req1_a;
    logic [BW-1:0] req0_b, req1_b;
    logic          rsp_valid, rsp_ready, rsp_id, rsp_dz;
    logic [DW-1:0] rsp_quot;
    logic [BW-1:0] rsp_rem;

    div_sched #(.DW(DW), .BW(BW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_quot   (rsp_quot),
        .rsp_rem    (rsp_rem),
        .rsp_dz     (rsp_dz)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cap_q, cap_r, cap_id, cap_dz, cap_lat;

    typedef struct {
        int rq;
        int a;
        int b;
        int exp_q;
        int exp_r;
    } vec_t;

    vec_t vecs[7];

    task automatic check_eq(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and wait for its response; consume it unless told not to.
    task automatic run_one(input int rq, input int a, input int b, input bit consume);
        bit seen;
        rsp_ready = 1'b0;
        if (rq == 0) begin
            req0_valid = 1'b1; req0_a = DW'(a); req0_b = BW'(b);
        end else begin
            req1_valid = 1'b1; req1_a = DW'(a); req1_b = BW'(b);
        end
        #1;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if ((rq == 0) ? req0_ready : req1_ready) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (!seen) begin
            check_eq("accept_timeout", 0, 1);
            req0_valid = 1'b0; req1_valid = 1'b0;
            cap_lat = 0;
            return;
        end
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        cap_lat = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (rsp_valid) begin
                cap_lat = k;
                break;
            end
        end
        if (cap_lat == 0) begin
            check_eq("rsp_timeout", 0, 1);
            return;
        end
        cap_q  = int'(rsp_quot);
        cap_r  = int'(rsp_rem);
        cap_id = int'(rsp_id);
        cap_dz = int'(rsp_dz);
        if (consume) begin
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
        end
    endtask

    task automatic check_div(input string tag, input int rq, input int a, input int b);
        run_one(rq, a, b, 1'b1);
        if (cap_lat != 0) begin
            check_eq({tag, "_quot"}, cap_q, a / b);
            check_eq({tag, "_rem"}, cap_r, a % b);
            check_eq({tag, "_id"}, cap_id, rq);
            check_eq({tag, "_lat"}, cap_lat, DW + 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nrsp, both, bad, acc, r0, r1;
        int rid[2], rqt[2], rrm[2];

        vecs[0] = '{0, 13, 3, 4, 1};
        vecs[1] = '{1, 10, 3, 3, 1};
        vecs[2] = '{0, 15, 1, 15, 0};
        vecs[3] = '{1, 0, 2, 0, 0};
        vecs[4] = '{0, 7, 2, 3, 1};
        vecs[5] = '{1, 15, 3, 5, 0};
        vecs[6] = '{0, 14, 3, 4, 2};

        // Reset with both requesters already presenting the tie scenario.
        rst_n = 1'b0;
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 4'd15; req0_b = 2'd1;
        req1_valid = 1'b1; req1_a = 4'd10; req1_b = 2'd3;
        tick(); tick(); tick();
        check_eq("rst_rsp_valid", int'(rsp_valid), 0);
        check_eq("rst_rsp_id", int'(rsp_id), 0);
        check_eq("rst_rsp_quot", int'(rsp_quot), 0);
        check_eq("rst_rsp_rem", int'(rsp_rem), 0);
        check_eq("rst_rsp_dz", int'(rsp_dz), 0);
        check_eq("rst_req0_ready", int'(req0_ready), 0);
        check_eq("rst_req1_ready", int'(req1_ready), 0);
        rst_n = 1'b1;
        #1;

        // Tie from reset: requester 0 first, then requester 1.
        rsp_ready = 1'b1;
        nrsp = 0; both = 0;
        for (int k = 0; k < 60 && nrsp < 2; k++) begin
            r0 = int'(req0_ready);
            r1 = int'(req1_ready);
            if (r0 != 0 && r1 != 0) both++;
            if (rsp_valid) begin
                rid[nrsp] = int'(rsp_id);
                rqt[nrsp] = int'(rsp_quot);
                rrm[nrsp] = int'(rsp_rem);
                nrsp++;
            end
            tick();
            if (r0 != 0) req0_valid = 1'b0;
            if (r1 != 0) req1_valid = 1'b0;
        end
        rsp_ready = 1'b0;
        check_eq("tie_rsp_count", nrsp, 2);
        check_eq("tie_both_ready", both, 0);
        if (nrsp == 2) begin
            check_eq("tie_first_id", rid[0], 0);
            check_eq("tie_first_quot", rqt[0], 15);
            check_eq("tie_first_rem", rrm[0], 0);
            check_eq("tie_second_id", rid[1], 1);
            check_eq("tie_second_quot", rqt[1], 3);
            check_eq("tie_second_rem", rrm[1], 1);
        end

        // Hand-computed vector table.
        foreach (vecs[i]) begin
            run_one(vecs[i].rq, vecs[i].a, vecs[i].b, 1'b1);
            if (cap_lat != 0) begin
                check_eq($sformatf("vec%0d_quot", i), cap_q, vecs[i].exp_q);
                check_eq($sformatf("vec%0d_rem", i), cap_r, vecs[i].exp_r);
                check_eq($sformatf("vec%0d_id", i), cap_id, vecs[i].rq);
                check_eq($sformatf("vec%0d_lat", i), cap_lat, DW + 1);
                check_eq($sformatf("vec%0d_dz", i), cap_dz, 0);
            end
        end

        // Stalled response: outputs hold, no accept until released.
        run_one(0, 11, 3, 1'b0);
        check_eq("stall_quot", cap_q, 3);
        check_eq("stall_rem", cap_r, 2);
        req1_valid = 1'b1; req1_a = 4'd5; req1_b = 2'd2;
        bad = 0; acc = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (rsp_valid !== 1'b1 || int'(rsp_quot) != cap_q || int'(rsp_rem) != cap_r
                || int'(rsp_id) != cap_id || int'(rsp_dz) != cap_dz) bad++;
            if (req1_ready) acc++;
        end
        check_eq("stall_unstable_cycles", bad, 0);
        check_eq("stall_accepts", acc, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_eq("stall_release_valid", int'(rsp_valid), 0);
        check_eq("stall_release_ready1", int'(req1_ready), 1);
        check_div("after_stall", 1, 5, 2);

        // Zero divisor.
        run_one(1, 9, 0, 1'b1);
`ifdef DIV_SCHED_DZ_EN
        check_eq("dz_lat", cap_lat, 1);
        check_eq("dz_quot", cap_q, 15);
        check_eq("dz_rem", cap_r, 1);
        check_eq("dz_flag", cap_dz, 1);
`else
        check_eq("dz_lat", cap_lat, DW + 1);
        check_eq("dz_quot", cap_q, 15);
        check_eq("dz_flag", cap_dz, 0);
`endif

        // Reset in the middle of an iteration: no response afterwards.
        req0_valid = 1'b1; req0_a = 4'd7; req0_b = 2'd2;
        #1;
        tick();
        req0_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        check_eq("midrst_valid", int'(rsp_valid), 0);
        check_eq("midrst_quot", int'(rsp_quot), 0);
        check_eq("midrst_rem", int'(rsp_rem), 0);
        check_eq("midrst_id", int'(rsp_id), 0);
        check_eq("midrst_dz", int'(rsp_dz), 0);
        tick();
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (rsp_valid) bad++;
        end
        check_eq("midrst_spurious_rsp", bad, 0);
        // Last grant was requester 0 before reset; reset must restore priority to 0.
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check_eq("midrst_tie_ready0", int'(req0_ready), 1);
        check_eq("midrst_tie_ready1", int'(req1_ready), 0);
        req1_valid = 1'b0;
        check_div("midrst_next", 0, 7, 2);

        // Exhaustive sweep, alternating requesters.
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 4; b++) begin
                check_div($sformatf("sweep_%0d_%0d", a, b), (a * 3 + b) % 2, a, b);
            end
        end

        // Randomized requests.
        for (int i = 0; i < 40; i++) begin
            int ra, rb, rr;
            ra = int'($urandom_range(15, 0));
            rb = int'($urandom_range(3, 1));
            rr = int'($urandom_range(1, 0));
            check_div($sformatf("rand%0d", i), rr, ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/div_sched.md
# div_sched

Sequential controller and two-port scheduler for the 4-bit/2-bit non-restoring division datapath. It accepts divide requests from two requesters over valid/ready handshakes and arbitrates between them round-robin. It runs one non-restoring step per clock on a shared partial-remainder register, applies the final remainder correction, and returns quotient, remainder and requester ID on a single response channel. It sits between the requesting units and the divider arithmetic, replacing the fully unrolled combinational chain with an iterative, shared unit.

## Interface
- `DW`, 4: dividend and quotient width.
- `BW`, 2: divisor and remainder width.
- `clk` input, 1: single clock, rising edge.
- `rst_n` input, 1: reset, asynchronous, active-low.
- `req0_valid` input, 1: requester 0 has a divide pending.
- `req0_ready` output, 1: requester 0 accepted this cycle.
- `req0_a` input, DW: requester 0 dividend, unsigned.
- `req0_b` input, BW: requester 0 divisor, unsigned.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`: same as requester 0, for requester 1.
- `rsp_valid` output, 1: response available.
- `rsp_ready` input, 1: consumer accepts the response.
- `rsp_id` output, 1: requester index of this response.
- `rsp_quot` output, DW: quotient.
- `rsp_rem` output, BW: remainder.
- `rsp_dz` output, 1: divisor was zero.

## Operation
- FSM states: IDLE, ITER, FIX, DONE. Reset state is IDLE.
- IDLE:
  - Grant goes to the one valid requester. If both are valid, grant goes to the one not granted last.
  - `last_grant` resets to 1, so requester 0 wins the first tie.
  - `reqN_ready` = (state==IDLE) && granted. It is a combinational function of the valids and is never high for both requesters.
  - On accept, latch `a`, `b` and `id`; clear partial remainder P (width BW+2, two's complement) and the iteration counter; go to ITER.
- ITER:
  - Each cycle performs one step: {P,Q} shifted left one bit; P = P[msb] ? P+B : P−B; Q[0] = ~P[msb] of the new P.
  - The counter counts DW steps, then the FSM goes to FIX.
- FIX: if P[msb] is set, P = P+B. Then go to DONE.
- DONE:
  - `rsp_valid`=1. `rsp_quot`=Q, `rsp_rem`=P[BW-1:0], `rsp_id` = latched id.
  - On `rsp_valid && rsp_ready`, go to IDLE.
  - While stalled, all `rsp_*` outputs hold stable.
- Arithmetic: all operands are unsigned. The remainder is always < B and fits in BW bits. The quotient is exact for every A in 0..2^DW−1 and every B ≥ 1.
- Reset values: `rsp_valid`=0, `rsp_id`=0, `rsp_quot`=0, `rsp_rem`=0, `rsp_dz`=0. `reqN_ready` is 0 during reset.
- Reset mid-operation: the in-flight request is discarded and no response is issued. The FSM returns to IDLE and `last_grant` returns to 1.
- Only one request is in flight at a time. New requests are not accepted in ITER, FIX or DONE.

## Timing
- Accept on edge E0. ITER covers edges E1..E(DW). FIX is edge E(DW+1). `rsp_valid` is high from edge E(DW+1) onward, i.e. DW+1 cycles after accept (5 for the defaults).
- Response handshake on edge Ek moves the FSM to IDLE. The next accept is possible at the earliest on edge Ek+1.
- Maximum throughput is one divide per DW+3 cycles.
- `reqN_ready` is combinational from `reqN_valid` and state. No other input-to-output combinational paths exist.

## Configuration
- `DIV_SCHED_DZ_EN` defined:
  - B==0 at accept goes IDLE→DONE directly, skipping ITER and FIX.
  - Response: `rsp_quot` = all ones, `rsp_rem` = A[BW-1:0], `rsp_dz`=1, with 1-cycle latency.
- `DIV_SCHED_DZ_EN` undefined:
  - No zero detection; B==0 runs the normal iterations. The quotient is all ones; the remainder is whatever the datapath produces.
  - `rsp_dz` is tied to 0.

## Structure
- Package `div_sched_pkg` holds:
  - the state enum (IDLE, ITER, FIX, DONE);
  - the default DW/BW constants;
  - the counter width, $clog2(DW+1).
- Sub-module `div_nr_step`: one combinational non-restoring step with inputs P, Q, B and outputs P', Q'. The FIX add is done inline in the top level.

## Test plan
- `req0` A=13, B=3, single request → accepted on E0; `rsp_valid` on E5; quot=4, rem=1, id=0.
- Both requesters valid from reset, `req0`=(15,1), `req1`=(10,3), `rsp_ready`=1 → `req0` served first (quot=15, rem=0). Then `req1` (quot=3, rem=1, id=1). `req0_ready` and `req1_ready` are never high together.
- `rsp_ready` held 0 for 10 cycles after `rsp_valid` → outputs stable, no new accept while stalled. Release → IDLE next edge.
- A=9, B=0:
  - with `DIV_SCHED_DZ_EN` → `rsp_valid` 1 cycle after accept; quot=15, rem=1, dz=1;
  - without → `rsp_valid` after 5 cycles; quot=15, dz=0.
- `rst_n` pulsed low during ITER (A=7, B=2) → no response; `rsp_*` all 0. The next request, A=7, B=2, gives quot=3, rem=1, id=0.
- Exhaustive sweep of A=0..15 × B=1..3, alternating requesters → every response matches A/B and A%B with the correct id.
